// File: rtl/pc_stack.sv
// Fetch-stage program counter with relative branching and a LIFO return-address stack.
// One command per cycle, fixed priority call > ret > load > branch > inc; stack faults are sticky.
module pc_stack #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       OFF_W       = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               inc,
  input  logic                               load,
  input  logic                               branch,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               clear_err,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [OFF_W-1:0]                   offset,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned        DEPTH_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned        IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    CmdHold,
    CmdInc,
    CmdBranch,
    CmdLoad,
    CmdRet,
    CmdCall
  } cmd_e;

  cmd_e               cmd;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  off_ext;
  logic [ADDR_W-1:0]  stack_top;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               ovf_set, unf_set;
  logic               push_en;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   top_idx;
  logic               is_empty, is_full;

  // Storage is deliberately unreset; only entries below depth are ever read.
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  // Command decode, highest priority first.
  always_comb begin
    cmd = CmdHold;
    if (call) begin
      cmd = CmdCall;
    end else if (ret) begin
      cmd = CmdRet;
    end else if (load) begin
      cmd = CmdLoad;
    end else if (branch) begin
      cmd = CmdBranch;
    end else if (inc) begin
      cmd = CmdInc;
    end
  end

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_MAX);

  // Sign-extend the branch displacement to the full address width.
  always_comb begin
    off_ext              = {ADDR_W{offset[OFF_W-1]}};
    off_ext[OFF_W-1:0]   = offset;
  end

  assign pc_inc    = pc_q + 1'b1;
  assign push_idx  = IDX_W'(depth_q);
  assign top_idx   = IDX_W'(depth_q - 1'b1);
  assign stack_top = stack_q[top_idx];

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (cmd)
      CmdCall: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          push_en = 1'b1;
          depth_d = depth_q + 1'b1;
          pc_d    = target;
        end
      end
      CmdRet: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          depth_d = depth_q - 1'b1;
          pc_d    = stack_top;
        end
      end
      CmdLoad:   pc_d = target;
      CmdBranch: pc_d = pc_q + off_ext;
      CmdInc:    pc_d = pc_inc;
      default:   pc_d = pc_q;
    endcase
  end

  // A new fault in the same cycle as clear_err leaves the flag set.
  assign overflow_d  = ovf_set | (overflow_q & ~clear_err);
  assign underflow_d = unf_set | (underflow_q & ~clear_err);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_VEC;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

`ifndef SYNTHESIS
  depth_in_range: assert property (@(posedge clock) disable iff (!reset_n) depth_q <= DEPTH_MAX);
`endif

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with relative branching and a hardware return-address stack for subroutine call/return. It sits in the fetch stage and supplies the instruction address to program memory. The control decoder drives one-cycle command strobes, and the datapath supplies the jump target and branch offset. Stack faults are reported as sticky flags for the control unit to inspect.

## Interface
- ADDR_W, 16, program counter / address width in bits (≥ 4)
- OFF_W, 8, width of signed branch offset (2 ≤ OFF_W ≤ ADDR_W)
- STACK_DEPTH, 4, return-address stack entries (≥ 1)
- RESET_VEC, 0, pc value after reset (ADDR_W bits)

- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- inc  input  1  advance pc by 1
- load  input  1  absolute jump: pc ← target
- branch  input  1  relative jump: pc ← pc + sext(offset)
- call  input  1  push pc+1, then pc ← target
- ret  input  1  pop: pc ← top of stack
- clear_err  input  1  clear sticky overflow/underflow flags
- target  input  ADDR_W  absolute address for load/call
- offset  input  OFF_W  two's-complement branch displacement
- pc  output  ADDR_W  current program counter (registered)
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_empty  output  1  depth == 0
- stack_full  output  1  depth == STACK_DEPTH
- overflow  output  1  sticky; call attempted while full
- underflow  output  1  sticky; ret attempted while empty

## Operation
- Exactly one command executes per cycle. Fixed priority: call > ret > load > branch > inc > hold. Lower-priority strobes in the same cycle are ignored.
- call, stack not full:
  - stack[depth] ← pc + 1 (mod 2^ADDR_W)
  - depth ← depth + 1
  - pc ← target
- call, stack full:
  - nothing pushed; pc and depth unchanged
  - overflow ← 1
- ret, stack not empty:
  - pc ← stack[depth-1]
  - depth ← depth − 1
- ret, stack empty: pc and depth unchanged; underflow ← 1.
- load: pc ← target; stack untouched.
- branch: pc ← (pc + sign_extend(offset)) mod 2^ADDR_W. Wraps silently in both directions; no flag.
- inc: pc ← (pc + 1) mod 2^ADDR_W. All-ones wraps to 0.
- No strobe: all state holds.
- Stack is LIFO, indexed by depth; no circular overwrite on overflow.
- Sticky flags:
  - stay set until clear_err or reset
  - if clear_err and a new fault occur in the same cycle, the flag is set (set wins)
  - clear_err never affects pc, depth or stack contents
- stack_empty and stack_full are derived combinationally from the registered depth. They are consistent with depth in every cycle.
- Stack storage is not reset. Entries at index ≥ depth are don't-care and never observable at pc.

## Timing
- reset_n low, asynchronously, regardless of clock: pc = RESET_VEC, depth = 0, stack_empty = 1, stack_full = 0, overflow = 0, underflow = 0. Outputs hold these values while reset_n is low.
- Reset release is sampled synchronously: the first command is accepted on the first rising edge with reset_n high.
- Reset asserted mid-operation (e.g. during a call cycle) aborts the update. No partial push is retained; depth returns to 0.
- Latency: a command sampled at edge N is visible on pc/depth/flags after edge N. Commands issued on consecutive cycles each take effect.
- Back-to-back call then ret returns to the call-site pc+1 two edges after the call strobe.
- Inputs target and offset are sampled only in the cycle of their strobe. No holding requirement otherwise.

## Test plan
- Reset and inc: ADDR_W=16, reset_n pulsed low mid-cycle → pc=0x0000 immediately. Then 3 inc cycles → pc=0x0003. Then load target=0xFFFF followed by inc → pc=0x0000 (wrap).
- Branch both directions, ADDR_W=16, OFF_W=8:
  - pc=0x0010, offset=0xF0 (−16) → pc=0x0000
  - then offset=0x7F → pc=0x007F
  - pc=0x0002, offset=0xFC (−4) → pc=0xFFFE
- Nested call/ret, STACK_DEPTH=4, start pc=0x0100:
  - call 0x0200, then call 0x0300 → depth=2
  - ret → pc=0x0201, ret → pc=0x0101, depth=0, stack_empty=1
- Overflow: 4 calls from pc=0x0000 with targets 0x10, 0x20, 0x30, 0x40 → depth=4, stack_full=1. Fifth call target=0x50 → pc stays 0x0040, overflow=1. Four rets → pc=0x0031, 0x0021, 0x0011, 0x0001 in order.
- Underflow and sticky clear:
  - ret with depth=0 → pc unchanged, underflow=1
  - underflow stays 1 across 5 inc cycles
  - clear_err alone → 0
  - clear_err concurrent with a ret on empty → underflow=1
- Priority: with pc=0x0050, assert call+ret+load+branch+inc together (target=0x0AAA) → pc=0x0AAA, depth=1, top of stack=0x0051. Next cycle assert ret+load → pc=0x0051, depth=0.
